instr_fetch_ctrl: RTL and testbench

Fetch sequencer in front of InstructionMemory. It owns the PC and issues one word address per cycle to the memory. Returned instructions are tagged with their PC and buffered in a small prefetch FIFO, which feeds decode over a valid/ready handshake. It also handles branch/jump redirects by flushing the FIFO and squashing in-flight reads.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch block.
package fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Word-align a fetch target by clearing the byte offset.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO. Flush has priority over push and pop.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~flush_i & ~empty_o;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    // Storage: written on push; cleared only by reset so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one word read per cycle under a credit
// limit, tracks reads through a MEM_LAT-deep pipe and buffers returned words
// (tagged with their PC) in a prefetch FIFO that feeds decode.
//
// Handshake: if_valid is high whenever the FIFO is non-empty; the head entry
// is consumed at a rising edge where if_valid & if_ready are both high and no
// redirect is present. While if_valid=1 and if_ready=0 the head is held stable.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_LAT    = 2,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [31:0]  mem_addr,
    output logic         mem_req,
    input  logic [31:0]  mem_instr,
    output logic         if_valid,
    input  logic         if_ready,
    output logic [31:0]  if_instr,
    output logic [31:0]  if_pc,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         misalign_err,
    output logic [1:0]   dbg_state_o
);

    localparam int         CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] DEPTH_C = 8'(FIFO_DEPTH);

    fetch_state_e               state_q;
    logic [31:0]                pc_q;
    logic [31:0]                pc_d;
    logic [31:0]                last_addr_q;
    logic                       misalign_q;
    logic [MEM_LAT-1:0]         pipe_v_q;
    logic [MEM_LAT-1:0][31:0]   pipe_pc_q;

    logic [CW-1:0]              fifo_count;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [2*INSTR_W-1:0]       fifo_rdata;

    logic [7:0]                 inflight;
    logic [7:0]                 used;
    logic                       has_credit;
    logic                       last_credit;
    logic                       issue;
    logic [31:0]                issue_addr;
    logic                       exit_valid;
    logic [31:0]                exit_pc;

    // Count reads still travelling through the latency pipe (including the one exiting now).
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + 8'(pipe_v_q[i]);
        end
    end

    // Credit check: a read is issued only if its word is guaranteed a FIFO slot.
    assign used        = 8'(fifo_count) + inflight;
    assign has_credit  = (used < DEPTH_C) && !fifo_full;
    assign last_credit = ((used + 8'd1) >= DEPTH_C);

    // A redirect always issues (it frees every credit); otherwise only FETCH issues.
    assign issue      = redirect_valid | ((state_q == FETCH) && has_credit);
    assign issue_addr = redirect_valid ? align_pc(redirect_pc) : pc_q;
    assign pc_d       = issue_addr + PC_INC;
    assign mem_req    = issue;
    assign mem_addr   = issue ? issue_addr : last_addr_q;

    assign exit_valid = pipe_v_q[MEM_LAT-1];
    assign exit_pc    = pipe_pc_q[MEM_LAT-1];

    fetch_fifo #(
        .WIDTH (2 * INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (exit_valid),
        .wdata_i ({mem_instr, exit_pc}),
        .pop_i   (if_ready & ~redirect_valid),
        .flush_i (redirect_valid),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign if_valid     = ~fifo_empty;
    assign if_instr     = fifo_rdata[2*INSTR_W-1:INSTR_W];
    assign if_pc        = fifo_rdata[INSTR_W-1:0];
    assign misalign_err = misalign_q;
    assign dbg_state_o  = state_q;

    // Latency pipe: a redirect squashes every older read, keeping only its own request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_q  <= '0;
            pipe_pc_q <= '0;
        end else begin
            pipe_v_q[0]  <= issue;
            pipe_pc_q[0] <= issue_addr;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_v_q[i]  <= pipe_v_q[i-1] & ~redirect_valid;
                pipe_pc_q[i] <= pipe_pc_q[i-1];
            end
        end
    end

    // PC, last driven address and the sticky misalignment flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            last_addr_q <= RESET_PC;
            misalign_q  <= 1'b0;
        end else begin
            if (issue) begin
                pc_q        <= pc_d;
                last_addr_q <= issue_addr;
            end
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
        end
    end

    // Sequencing FSM: BOOT idles one cycle, FETCH issues, HOLD waits for credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else if (redirect_valid) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                BOOT:    state_q <= FETCH;
                FETCH:   if (!has_credit || last_credit) state_q <= HOLD;
                HOLD:    if (has_credit) state_q <= FETCH;
                default: state_q <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: reset and start-up/back-pressure table, directed
// redirect/reset/wrap sequences, then randomized traffic checked by a
// stream-level model of the delivered and requested PC sequences.
module tb_instr_fetch_ctrl;

    localparam int          MEM_LAT  = 2;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_bad;
    int pops;

    instr_fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .MEM_LAT    (MEM_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_req        (mem_req),
        .mem_instr      (mem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction memory: word n = 0x1000_0000 + n ----------------
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Address history sampled mid-cycle; the word for a cycle-t address is
    // presented through the rising edge that ends cycle t+MEM_LAT.
    logic [31:0] hist [MEM_LAT+1];
    always @(negedge clk) begin
        for (int i = MEM_LAT; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = mem_addr;
    end
    assign mem_instr = word_of(hist[MEM_LAT]);

    // ---------------- checking helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stream-level reference model ----------------
    // Delivered PCs form a +4 sequence restarting at each redirect target;
    // requested addresses likewise; misalign_err is the OR of misaligned targets.
    logic [31:0] m_exp_pc;
    logic [31:0] m_issue_pc;
    logic [31:0] m_last_addr;
    logic        m_mis;
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_exp_pc    = RESET_PC;
            m_issue_pc  = RESET_PC;
            m_last_addr = RESET_PC;
            m_mis       = 1'b0;
            prev_hold   = 1'b0;
        end else begin
            check32("misalign_err", 32'(misalign_err), 32'(m_mis));
            if (prev_hold) begin
                check32("hold_valid", 32'(if_valid), 32'd1);
                check32("hold_pc", if_pc, prev_pc);
                check32("hold_instr", if_instr, prev_instr);
            end
            if (redirect_valid) begin
                check32("redir_req", 32'(mem_req), 32'd1);
                check32("redir_addr", mem_addr, {redirect_pc[31:2], 2'b00});
                m_exp_pc    = {redirect_pc[31:2], 2'b00};
                m_last_addr = m_exp_pc;
                m_issue_pc  = m_exp_pc + 32'd4;
                if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
            end else begin
                if (mem_req) begin
                    check32("issue_addr", mem_addr, m_issue_pc);
                    m_last_addr = m_issue_pc;
                    m_issue_pc  = m_issue_pc + 32'd4;
                end else begin
                    check32("idle_addr", mem_addr, m_last_addr);
                end
                if (if_valid && if_ready) begin
                    check32("pop_pc", if_pc, m_exp_pc);
                    check32("pop_instr", if_instr, word_of(m_exp_pc));
                    m_exp_pc = m_exp_pc + 32'd4;
                    pops++;
                end
            end
            prev_hold  = if_valid && !if_ready && !redirect_valid;
            prev_pc    = if_pc;
            prev_instr = if_instr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // Wait (bounded) for if_valid; n = edges waited, 0 on timeout.
    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
            #1;
            if (if_valid) begin
                n = k;
                break;
            end
        end
        n_vec++;
        if (n == 0) begin
            n_bad++;
            $display("FAIL wait_valid: no if_valid within %0d cycles (t=%0t)", max_cyc, $time);
        end
    endtask

    // ---------------- start-up / back-pressure table ----------------
    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t tbl [15];

    initial begin : main
        int n;
        int pops_before;
        int mode;

        n_vec = 0;
        n_bad = 0;
        pops  = 0;
        mode  = 0;
        rst_n = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Rows: sample taken just after each rising edge following reset release.
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 2'd1};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 2'd1};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b0, 32'h00, 2'd1};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00, 2'd1};
        tbl[4]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h00, 2'd2};
        tbl[5]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h00, 2'd2};
        tbl[6]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h00, 2'd2};
        tbl[7]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h00, 2'd2};
        tbl[8]  = '{1'b0, 1'b0, 32'h0C, 1'b1, 32'h00, 2'd2};
        tbl[9]  = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h00, 2'd2};
        tbl[10] = '{1'b1, 1'b0, 32'h0C, 1'b1, 32'h04, 2'd2};
        tbl[11] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 2'd1};
        tbl[12] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 2'd1};
        tbl[13] = '{1'b1, 1'b1, 32'h18, 1'b0, 32'h00, 2'd1};
        tbl[14] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 2'd1};

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check32("rst_mem_req", 32'(mem_req), 32'd0);
        check32("rst_mem_addr", mem_addr, RESET_PC);
        check32("rst_if_valid", 32'(if_valid), 32'd0);
        check32("rst_if_instr", if_instr, 32'd0);
        check32("rst_if_pc", if_pc, 32'd0);
        check32("rst_misalign", 32'(misalign_err), 32'd0);
        check32("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        #1;
        check32("boot_state", 32'(dbg_state), 32'd0);
        check32("boot_req", 32'(mem_req), 32'd0);

        // ---- start-up latency, fill to HOLD, drain ----
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if_ready = tbl[i].rdy;
            #1;
            check32($sformatf("tbl%0d_req", i), 32'(mem_req), 32'(tbl[i].exp_req));
            check32($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
            check32($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].exp_valid));
            check32($sformatf("tbl%0d_state", i), 32'(dbg_state), 32'(tbl[i].exp_state));
            if (tbl[i].exp_valid) begin
                check32($sformatf("tbl%0d_pc", i), if_pc, tbl[i].exp_pc);
                check32($sformatf("tbl%0d_instr", i), if_instr, word_of(tbl[i].exp_pc));
            end
        end

        // ---- redirect to 0x40 with a partly full FIFO and reads in flight ----
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h40);
        #1;
        check32("r40_req", 32'(mem_req), 32'd1);
        check32("r40_addr", mem_addr, 32'h40);
        wait_valid(10, n);
        check32("r40_latency", 32'(n), 32'(MEM_LAT + 1));
        check32("r40_first_pc", if_pc, 32'h40);
        @(posedge clk);
        #2;
        check32("r40_second_pc", if_pc, 32'h44);

        // ---- misaligned redirect, then aligned one: flag stays set ----
        drive(1'b1, 1'b1, 32'h42);
        wait_valid(10, n);
        check32("r42_misalign", 32'(misalign_err), 32'd1);
        check32("r42_first_pc", if_pc, 32'h40);
        drive(1'b1, 1'b1, 32'h100);
        wait_valid(10, n);
        check32("r100_misalign", 32'(misalign_err), 32'd1);
        check32("r100_first_pc", if_pc, 32'h100);

        // ---- redirect in the same cycle as a pop, then back-to-back redirects ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        drive(1'b1, 1'b1, 32'h80);
        drive(1'b1, 1'b1, 32'hC0);
        wait_valid(10, n);
        check32("b2b_latency", 32'(n), 32'(MEM_LAT + 1));
        check32("b2b_first_pc", if_pc, 32'hC0);
        @(posedge clk);
        #2;
        check32("b2b_second_pc", if_pc, 32'hC4);

        // ---- asynchronous reset mid-stream ----
        repeat (6) drive(1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check32("mid_rst_valid", 32'(if_valid), 32'd0);
        check32("mid_rst_req", 32'(mem_req), 32'd0);
        check32("mid_rst_state", 32'(dbg_state), 32'd0);
        check32("mid_rst_misalign", 32'(misalign_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_valid(10, n);
        check32("restart_latency", 32'(n), 32'(MEM_LAT + 2));
        check32("restart_pc", if_pc, RESET_PC);

        // ---- PC wrap at the top of the address space ----
        drive(1'b1, 1'b1, 32'hFFFF_FFFC);
        wait_valid(10, n);
        check32("wrap_first_pc", if_pc, 32'hFFFF_FFFC);
        @(posedge clk);
        #2;
        check32("wrap_valid", 32'(if_valid), 32'd1);
        check32("wrap_second_pc", if_pc, 32'h0000_0000);

        // ---- randomized traffic against the stream model ----
        pops_before = pops;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            if (c % 64 == 0) mode = int'($urandom_range(0, 2));
            case (mode)
                0:       if_ready = 1'b1;
                1:       if_ready = ($urandom_range(0, 3) != 0);
                default: if_ready = ($urandom_range(0, 3) == 0);
            endcase
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom();
                1:       redirect_pc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
                default: redirect_pc = 32'($urandom_range(0, 1023)) << 2;
            endcase
        end
        repeat (20) drive(1'b1, 1'b0, 32'h0);
        n_vec++;
        if ((pops - pops_before) < 100) begin
            n_bad++;
            $display("FAIL liveness: %0d pops in random phase, expected at least 100", pops - pops_before);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // ---------------- global time bound ----------------
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got t=%0t, expected completion before 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
